// File: rtl/console_uart_tx.sv
// Console transmitter: snoops byte stores to CONSOLE_ADDRESS, queues them in a FIFO and sends them as 8N1 UART frames.
// Optional macro CONSOLE_UART_PARITY_EN inserts an even-parity bit, giving 8E1 frames.

`ifndef WRITE
`define WRITE 1'b1
`endif

module console_uart_tx #(
  parameter logic [31:0] CONSOLE_ADDRESS = 32'h1000_0000,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          CLKS_PER_BIT    = 868
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_memory_interface_enable,
  input  logic                          data_memory_interface_state,
  input  logic [31:0]                   data_memory_interface_address,
  input  logic [3:0]                    data_memory_interface_frame_mask,
  input  logic [31:0]                   data_memory_interface_data,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   overflow_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef CONSOLE_UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_ovf;
  logic [BW-1:0]    r_baud;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_tx;
  logic             w_tx_next;
  logic             w_bit_adv;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_baud_done;
  logic [7:0]       w_rd_data;
  logic             w_unused;
`ifdef CONSOLE_UART_PARITY_EN
  logic             r_parity;
`endif

  // Only lane 3 (data[7:0]) carries the console byte; the rest of the bus is snooped but irrelevant.
  assign w_unused = ^{data_memory_interface_data[31:8], data_memory_interface_frame_mask[2:0]};

  assign w_push_req = data_memory_interface_enable
                    && (data_memory_interface_state == `WRITE)
                    && (data_memory_interface_address == CONSOLE_ADDRESS)
                    && data_memory_interface_frame_mask[3];
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  assign w_push      = w_push_req && ((r_count != CNT_W'(FIFO_DEPTH)) || w_pop);
  assign w_drop      = w_push_req && !w_push;
  assign w_rd_data   = r_mem[r_rptr];
  assign w_baud_done = (r_baud == BW'(CLKS_PER_BIT - 1));

  assign uart_tx        = r_tx;
  assign busy           = (r_state != S_IDLE);
  assign fifo_empty     = (r_count == '0);
  assign fifo_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign fifo_count     = r_count;
  assign overflow_count = r_ovf;

  // FIFO storage holds data only, so it is left out of the reset domain.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= data_memory_interface_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_ovf != 16'hFFFF)) begin
        r_ovf <= r_ovf + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_pop) w_state_next = S_START;
      S_START:  if (w_baud_done) w_state_next = S_DATA;
      S_DATA: begin
        if (w_baud_done && (r_bit == 3'd7)) begin
`ifdef CONSOLE_UART_PARITY_EN
          w_state_next = S_PARITY;
`else
          w_state_next = S_STOP;
`endif
        end
      end
`ifdef CONSOLE_UART_PARITY_EN
      S_PARITY: if (w_baud_done) w_state_next = S_STOP;
`endif
      S_STOP:   if (w_baud_done) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // The line level is chosen one cycle ahead so that r_tx changes on the same edge as the state.
  always_comb begin
    w_tx_next = r_tx;
    w_bit_adv = 1'b0;
    case (r_state)
      S_IDLE:  w_tx_next = !w_pop;
      S_START: if (w_baud_done) w_tx_next = r_shift[0];
      S_DATA: begin
        if (w_baud_done) begin
          if (r_bit == 3'd7) begin
`ifdef CONSOLE_UART_PARITY_EN
            w_tx_next = r_parity;
`else
            w_tx_next = 1'b1;
`endif
          end else begin
            w_tx_next = r_shift[1];
            w_bit_adv = 1'b1;
          end
        end
      end
`ifdef CONSOLE_UART_PARITY_EN
      S_PARITY: if (w_baud_done) w_tx_next = 1'b1;
`endif
      S_STOP:  if (w_baud_done) w_tx_next = 1'b1;
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx   <= 1'b1;
      r_baud <= '0;
      r_bit  <= '0;
    end else begin
      r_tx <= w_tx_next;
      if ((r_state == S_IDLE) || w_baud_done) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + BW'(1);
      end
      if (r_state != S_DATA) begin
        r_bit <= '0;
      end else if (w_bit_adv) begin
        r_bit <= r_bit + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift <= w_rd_data;
    end else if (w_bit_adv) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

`ifdef CONSOLE_UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_parity <= ^w_rd_data;
    end
  end
`endif

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: a serial-line monitor decodes frames and checks them against a queue of expected bytes.

`ifndef WRITE
`define WRITE 1'b1
`endif
`ifndef READ
`define READ 1'b0
`endif

module tb_console_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef CONSOLE_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME  = NBITS * CPB;
  localparam int STOP_C = (NBITS - 1) * CPB + CPB / 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        st = `READ;
  logic [31:0] addr = '0;
  logic [3:0]  mask = '0;
  logic [31:0] data = '0;
  logic        uart_tx;
  logic        busy;
  logic        fifo_empty;
  logic        fifo_full;
  logic [4:0]  fifo_count;
  logic [15:0] overflow_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  console_uart_tx #(
    .CONSOLE_ADDRESS(32'h1000_0000),
    .FIFO_DEPTH(DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_memory_interface_enable(en),
    .data_memory_interface_state(st),
    .data_memory_interface_address(addr),
    .data_memory_interface_frame_mask(mask),
    .data_memory_interface_data(data),
    .uart_tx(uart_tx),
    .busy(busy),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .fifo_count(fifo_count),
    .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [3:0] m, input logic s, input logic [7:0] b);
    @(posedge clk);
    #1;
    en = 1'b1; addr = a; mask = m; st = s; data = {24'hA5C3E7, b};
  endtask

  task automatic bus_idle();
    @(posedge clk);
    #1;
    en = 1'b0; addr = '0; mask = '0; st = `READ; data = '0;
  endtask

  // Line monitor: start bit detected at the first falling-clock sample, bits sampled mid-cell.
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = '0;
  logic       mon_start_ok = 1'b1;
  logic       mon_par = 1'b0;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1; mon_cnt = 0; mon_byte = '0; mon_start_ok = 1'b1;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2 && uart_tx !== 1'b0) mon_start_ok = 1'b0;
      if (mon_cnt >= CPB + CPB / 2 && mon_cnt < 9 * CPB && ((mon_cnt - CPB / 2) % CPB) == 0)
        mon_byte[(mon_cnt - CPB / 2) / CPB - 1] = uart_tx;
      if (mon_cnt == 9 * CPB + CPB / 2) mon_par = uart_tx;
      if (mon_cnt == STOP_C) begin
        mon_active = 1'b0;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_frame: got byte 0x%0h with nothing expected", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("frame_byte", {24'd0, mon_byte}, {24'd0, mon_exp});
          chk("start_bit", {31'd0, mon_start_ok}, 32'd1);
          chk("stop_bit", {31'd0, uart_tx}, 32'd1);
`ifdef CONSOLE_UART_PARITY_EN
          chk("parity_bit", {31'd0, mon_par}, {31'd0, ^mon_exp});
`endif
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi1, lo, hi2, ph, bad;

    // Reset state
    #23;
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_count", {27'd0, fifo_count}, 32'd0);
    chk("rst_ovf", {16'd0, overflow_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single 0x41 frame, latency and busy duration
    exp_q.push_back(8'h41);
    do_store(32'h1000_0000, 4'b1000, `WRITE, 8'h41);
    bus_idle();
    chk("t1_count_after_push", {27'd0, fifo_count}, 32'd1);
    chk("t1_busy_before_pop", {31'd0, busy}, 32'd0);
    chk("t1_tx_before_pop", {31'd0, uart_tx}, 32'd1);
    @(posedge clk);
    #1;
    chk("t1_tx_start", {31'd0, uart_tx}, 32'd0);
    chk("t1_busy_start", {31'd0, busy}, 32'd1);
    chk("t1_count_after_pop", {27'd0, fifo_count}, 32'd0);
    hi1 = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) hi1++;
      else break;
    end
    chk("t1_busy_cycles", hi1, FRAME);

    // Non-matching transactions
    do_store(32'h1000_0004, 4'b1000, `WRITE, 8'h11);
    do_store(32'h1000_0000, 4'b0111, `WRITE, 8'h22);
    do_store(32'h1000_0000, 4'b1000, `READ, 8'h33);
    bus_idle();
    repeat (10) @(negedge clk);
    chk("t2_tx", {31'd0, uart_tx}, 32'd1);
    chk("t2_count", {27'd0, fifo_count}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd0);

    // Back-to-back frames: frame length and one-cycle idle gap
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h43);
    do_store(32'h1000_0000, 4'b1000, `WRITE, 8'h41);
    do_store(32'h1000_0000, 4'b1000, `WRITE, 8'h43);
    bus_idle();
    hi1 = 0; lo = 0; hi2 = 0; ph = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ph == 0) begin
        if (busy) hi1++;
        else if (hi1 > 0) begin ph = 1; lo = 1; end
      end else if (ph == 1) begin
        if (busy) begin ph = 2; hi2 = 1; end
        else lo++;
      end else begin
        if (busy) hi2++;
        else break;
      end
    end
    chk("bb_frame1_cycles", hi1, FRAME);
    chk("bb_gap_cycles", lo, 1);
    chk("bb_frame2_cycles", hi2, FRAME);
    repeat (4) @(negedge clk);

    // Overflow: 18 consecutive stores into a 16-deep FIFO
    for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 18; i++) do_store(32'h1000_0000, 4'b1000, `WRITE, 8'(i));
    bus_idle();
    chk("t3_ovf", {16'd0, overflow_count}, 32'd1);
    chk("t3_full", {31'd0, fifo_full}, 32'd1);
    chk("t3_count", {27'd0, fifo_count}, 32'd16);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    repeat (FRAME) @(negedge clk);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_empty", {31'd0, fifo_empty}, 32'd1);
    chk("t3_ovf_hold", {16'd0, overflow_count}, 32'd1);

    // Asynchronous reset mid-DATA with 5 bytes still queued
    do_store(32'h1000_0000, 4'b1000, `WRITE, 8'h00);
    for (int i = 0; i < 5; i++) do_store(32'h1000_0000, 4'b1000, `WRITE, 8'h55);
    bus_idle();
    @(posedge clk);
    #3;
    chk("t4_tx_in_data", {31'd0, uart_tx}, 32'd0);
    chk("t4_queued", {27'd0, fifo_count}, 32'd5);
    reset = 1'b0;
    #1;
    chk("t4_tx_async", {31'd0, uart_tx}, 32'd1);
    chk("t4_empty_async", {31'd0, fifo_empty}, 32'd1);
    chk("t4_busy_async", {31'd0, busy}, 32'd0);
    chk("t4_ovf_async", {16'd0, overflow_count}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0) bad++;
    end
    chk("t4_idle_after_release", bad, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
